// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C configuration sequencer: state encoding and
// the 24-bit write frame layout {addr[6:0], rw, reg[7:0], data[7:0]}.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StWait,
        StGap,
        StDone,
        StError
    } seq_state_e;

    localparam int unsigned FrameW  = 24;
    localparam int unsigned AddrLsb = 17;
    localparam int unsigned RwBit   = 16;
    localparam int unsigned RegLsb  = 8;
    localparam int unsigned DataLsb = 0;

    localparam logic WriteBit = 1'b0;

    function automatic logic [FrameW-1:0] build_frame(input logic [6:0]  addr,
                                                      input logic [15:0] reg_data);
        logic [FrameW-1:0] frame;
        frame                 = '0;
        frame[AddrLsb +: 7]   = addr;
        frame[RwBit]          = WriteBit;
        frame[RegLsb +: 8]    = reg_data[15:8];
        frame[DataLsb +: 8]   = reg_data[7:0];
        return frame;
    endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// Combinational 16-entry configuration table; each word is {reg[7:0], data[7:0]}.
module i2c_cfg_rom (
    input  logic [3:0]  addr_i,
    output logic [15:0] word_o
);

    always_comb begin
        word_o = 16'h0000;
        unique case (addr_i)
            4'd0:    word_o = 16'h1E00;
            4'd1:    word_o = 16'h0217;
            4'd2:    word_o = 16'h0417;
            4'd3:    word_o = 16'h0679;
            4'd4:    word_o = 16'h0879;
            4'd5:    word_o = 16'h0A12;
            4'd6:    word_o = 16'h0C00;
            4'd7:    word_o = 16'h0E01;
            4'd8:    word_o = 16'h1001;
            4'd9:    word_o = 16'h1200;
            4'd10:   word_o = 16'h1402;
            4'd11:   word_o = 16'h1604;
            4'd12:   word_o = 16'h1808;
            4'd13:   word_o = 16'h1A10;
            4'd14:   word_o = 16'h1C20;
            4'd15:   word_o = 16'h1F40;
            default: word_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/i2c_cfg_seq.sv
// Walks the configuration table, issuing one I2C write per word with retries,
// an inter-transaction gap and a per-transaction watchdog.
module i2c_cfg_seq
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = 8,
    parameter logic [6:0]  DEV_ADDR   = 7'h1A,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    output logic        tx_start,
    output logic [23:0] tx_data,
    input  logic        tx_busy,
    input  logic        tx_done,
    input  logic        tx_ack_err,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  idx
);

    localparam logic [3:0] LastIdx  = 4'(NUM_WORDS - 1);
    localparam logic [7:0] MaxRetry = 8'(MAX_RETRY);
    localparam logic [7:0] GapLast  = 8'(GAP_CYCLES - 1);
    localparam logic [9:0] WdogLast = 10'(TIMEOUT - 1);

    seq_state_e        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [7:0]        retry_q, retry_d;
    logic [7:0]        gap_q, gap_d;
    logic [9:0]        wdog_q, wdog_d;
    logic              retry_pend_q, retry_pend_d;
    logic [FrameW-1:0] tx_data_q, tx_data_d;

    logic [15:0] rom_word;
    logic        wait_ok;
    logic        wait_fail;

    i2c_cfg_rom u_rom (
        .addr_i (idx_q),
        .word_o (rom_word)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            retry_q      <= '0;
            gap_q        <= '0;
            wdog_q       <= '0;
            retry_pend_q <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            gap_q        <= gap_d;
            wdog_q       <= wdog_d;
            retry_pend_q <= retry_pend_d;
            tx_data_q    <= tx_data_d;
        end
    end

    // tx_done/tx_ack_err only matter while waiting on the transmitter.
    assign wait_ok   = (state_q == StWait) && tx_done && !tx_ack_err;
    assign wait_fail = (state_q == StWait) &&
                       ((tx_done && tx_ack_err) || (!tx_done && wdog_q == WdogLast));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        gap_d        = gap_q;
        wdog_d       = wdog_q;
        retry_pend_d = retry_pend_q;
        tx_data_d    = tx_data_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (go) begin
                    state_d = StLoad;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            StLoad: begin
                tx_data_d = build_frame(DEV_ADDR, rom_word);
                state_d   = StIssue;
            end
            StIssue: begin
                if (!tx_busy) begin
                    wdog_d  = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                wdog_d = wdog_q + 10'd1;
                if (wait_ok) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        gap_d        = '0;
                        retry_pend_d = 1'b0;
                        state_d      = StGap;
                    end
                end else if (wait_fail) begin
                    if (retry_q == MaxRetry) begin
                        state_d = StError;
                    end else begin
                        retry_d      = retry_q + 8'd1;
                        gap_d        = '0;
                        retry_pend_d = 1'b1;
                        state_d      = StGap;
                    end
                end
            end
            StGap: begin
                gap_d = gap_q + 8'd1;
                if (gap_q == GapLast) begin
                    // A retry re-issues the already latched frame; success moves on.
                    if (retry_pend_q) begin
                        state_d = StIssue;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        retry_d = '0;
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_start = (state_q == StIssue) && !tx_busy;
        tx_data  = tx_data_q;
        busy     = (state_q == StLoad) || (state_q == StIssue) ||
                   (state_q == StWait) || (state_q == StGap);
        done     = (state_q == StDone);
        error    = (state_q == StError);
        idx      = idx_q;
    end

endmodule

// File: doc/i2c_cfg_seq.md
I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

Interface
REQ-001 Parameter NUM_WORDS, 8, number of table writes per sequence (1..16).
REQ-002 Parameter DEV_ADDR, 7'h1A, 7-bit slave address for every write.
REQ-003 Parameter MAX_RETRY, 3, re-issues allowed per word after a failure.
REQ-004 Parameter GAP_CYCLES, 4, idle cycles between consecutive transactions (>=1).
REQ-005 Parameter TIMEOUT, 1023, maximum WAIT cycles before a transaction counts as failed.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 go  in  1  start request, sampled every cycle.
REQ-009 tx_start  out  1  one-cycle pulse: transmitter latches tx_data.
REQ-010 tx_data  out  24  {DEV_ADDR, 1'b0 write bit, reg[7:0], data[7:0]}.
REQ-011 tx_busy  in  1  transmitter occupied.
REQ-012 tx_done  in  1  one-cycle pulse: transaction finished.
REQ-013 tx_ack_err  in  1  NACK seen; valid only with tx_done.
REQ-014 busy  out  1  sequence in progress.
REQ-015 done  out  1  level: all words written without error.
REQ-016 error  out  1  level: sequence aborted.
REQ-017 idx  out  4  index of current/failing word.

Function
REQ-018 States: IDLE, LOAD, ISSUE, WAIT, GAP, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR + go=1 -> LOAD; idx=0, retry=0, done=0, error=0.
REQ-020 go while busy=1 is ignored.
REQ-021 LOAD: fetch table word idx; register tx_data; -> ISSUE next cycle.
REQ-022 ISSUE: tx_busy=0 -> tx_start=1 for exactly that cycle, -> WAIT; tx_busy=1 -> hold ISSUE, no pulse.
REQ-023 Latency: go at cycle N, tx_busy low -> tx_start at cycle N+2.
REQ-024 tx_data stays stable from LOAD exit until the next LOAD.
REQ-025 WAIT: tx_done=1, tx_ack_err=0 -> success; tx_done=1, tx_ack_err=1 -> failure.
REQ-026 WAIT timeout: after TIMEOUT cycles without tx_done -> failure.
REQ-027 Watchdog counter 10 bits; it clears on entry to WAIT.
REQ-028 Success, idx<NUM_WORDS-1 -> GAP; on GAP exit, idx+1 and retry=0, then -> LOAD.
REQ-029 Success, idx=NUM_WORDS-1 -> DONE; done=1, busy=0.
REQ-030 Failure, retry<MAX_RETRY -> retry+1, GAP, then ISSUE with the same word.
REQ-031 Failure, retry=MAX_RETRY -> ERROR; error=1, idx holds the failing word.
REQ-032 MAX_RETRY=0: the first failure goes to ERROR.
REQ-033 GAP lasts exactly GAP_CYCLES cycles.
REQ-034 tx_done outside WAIT is ignored.
REQ-035 busy=1 in LOAD, ISSUE, WAIT, GAP; 0 otherwise.
REQ-036 done and error are never 1 at the same time.

Reset
REQ-037 reset_n=0 at a clock edge -> IDLE; tx_start=0, tx_data=0, busy=0, done=0, error=0, idx=0, all counters 0.
REQ-038 Reset mid-sequence aborts it with no further tx_start; the transmitter is not notified.
REQ-039 After reset release, the first go is accepted in the first cycle.

Structure
REQ-040 Shared package i2c_pkg: state encoding, 24-bit frame layout/field offsets, write-bit constant.
REQ-041 Sub-module i2c_cfg_rom: combinational 16-entry table, 4-bit address in, {reg,data} 16-bit out.
REQ-042 Sequencer split: state register / next-state logic / output logic.

Verification
REQ-043 Defaults, ideal responder (tx_done 5 cycles after tx_start, no NACK), go pulse -> 8 tx_start pulses, each followed by 4-cycle gaps, frames match the ROM, then done=1, busy=0.
REQ-044 Word 3 NACKs twice, then ACKs -> three tx_start pulses carrying word 3, sequence completes, done=1.
REQ-045 Word 5 NACKs 4 times -> error=1, idx=5, no 5th tx_start, done=0.
REQ-046 Responder never sends tx_done -> 1023 WAIT cycles, 3 retries, then error=1.
REQ-047 tx_busy held high 20 cycles after LOAD -> tx_start delayed until the cycle tx_busy drops; go mid-sequence has no effect.
REQ-048 reset_n=0 for 1 cycle during WAIT of word 2 -> all outputs 0 next cycle; a new go restarts at idx=0.
